// File: rtl/i2s_transmitter_if.sv
// PCM sample handshake between the audio pipeline and the I2S transmitter.
// A stereo pair transfers on any clock where valid_in && ready_out.
interface i2s_transmitter_if #(
    parameter int DATA_WIDTH = 24
);
    logic signed [DATA_WIDTH-1:0] left_in;
    logic signed [DATA_WIDTH-1:0] right_in;
    logic                         valid_in;
    logic                         ready_out;

    modport master (
        output left_in,
        output right_in,
        output valid_in,
        input  ready_out
    );

    modport slave (
        input  left_in,
        input  right_in,
        input  valid_in,
        output ready_out
    );
endinterface

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: generates sclk/ws and shifts stereo PCM MSB-first,
// one sclk after each ws transition, from a single-entry holding buffer.
module i2s_transmitter #(
    parameter int SCLK_HALF_PERIOD = 16,
    parameter int SLOT_WIDTH       = 32,
    parameter int DATA_WIDTH       = 24
) (
    input  logic               clk_in,
    input  logic               rst_in,
    i2s_transmitter_if.slave   pcm,
    output logic               sclk_out,
    output logic               ws_out,
    output logic               sdata_out,
    output logic               frame_start_out,
    output logic               underrun_out
);
    localparam int HW = (SCLK_HALF_PERIOD > 1) ? $clog2(SCLK_HALF_PERIOD) : 1;
    localparam int BW = $clog2(2 * SLOT_WIDTH);
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] SLOT      = BW'(SLOT_WIDTH);

    logic [HW-1:0]                half_cnt_q, half_cnt_d;
    logic [BW-1:0]                bit_cnt_q, bit_cnt_d;
    logic                         sclk_q, sclk_d;
    logic                         ws_q, ws_d;
    logic                         sdata_q, sdata_d;
    logic                         fs_q, fs_d;
    logic                         ur_q, ur_d;
    logic                         full_q, full_d;
    logic signed [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic signed [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic signed [DATA_WIDTH-1:0] frame_l_q, frame_l_d;
    logic signed [DATA_WIDTH-1:0] frame_r_q, frame_r_d;
    logic signed [DATA_WIDTH-1:0] word;
    logic [BW-1:0]                b;
    logic [BW-1:0]                p;

    always_comb begin
        half_cnt_d = half_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        ws_d       = ws_q;
        sdata_d    = sdata_q;
        fs_d       = 1'b0;
        ur_d       = 1'b0;
        full_d     = full_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        frame_l_d  = frame_l_q;
        frame_r_d  = frame_r_q;
        word       = '0;
        b          = '0;
        p          = '0;

        if (half_cnt_q == HALF_LAST) begin
            half_cnt_d = '0;
            sclk_d     = ~sclk_q;
            if (sclk_q) begin
                b         = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
                bit_cnt_d = b;
                // The frame loads before bit 0 is selected; an empty buffer repeats the last pair.
                if (b == '0) begin
                    fs_d = 1'b1;
                    if (full_q) begin
                        frame_l_d = hold_l_q;
                        frame_r_d = hold_r_q;
                        full_d    = 1'b0;
                    end else begin
                        ur_d = 1'b1;
                    end
                end
                ws_d    = (b >= SLOT);
                word    = ws_d ? frame_r_d : frame_l_d;
                p       = ws_d ? b - SLOT : b;
                sdata_d = 1'b0;
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (int'(p) == DATA_WIDTH - i) sdata_d = word[i];
                end
            end
        end

        // Accept only into an empty buffer, so a same-cycle load never sees this pair.
        if (pcm.valid_in && !full_q) begin
            hold_l_d = pcm.left_in;
            hold_r_d = pcm.right_in;
            full_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            half_cnt_q <= '0;
            bit_cnt_q  <= BIT_LAST;
            sclk_q     <= 1'b0;
            ws_q       <= 1'b0;
            sdata_q    <= 1'b0;
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
            full_q     <= 1'b0;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
        end else begin
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            ws_q       <= ws_d;
            sdata_q    <= sdata_d;
            fs_q       <= fs_d;
            ur_q       <= ur_d;
            full_q     <= full_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
        end
    end

    always_ff @(posedge clk_in) begin
        hold_l_q <= hold_l_d;
        hold_r_q <= hold_r_d;
    end

    assign pcm.ready_out    = ~full_q;
    assign sclk_out         = sclk_q;
    assign ws_out           = ws_q;
    assign sdata_out        = sdata_q;
    assign frame_start_out  = fs_q;
    assign underrun_out     = ur_q;
endmodule
